// File: rtl/ro_puf_reader.sv
`timescale 1ns/1ps
// Ring-oscillator PUF reader: counts rising edges of two oscillators over a fixed window
// and reports which one is faster. Define ROPUF_MARGIN_EN to add the unstable margin flag.
module ro_puf_reader #(
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 64,
  parameter int WINDOW_CYC = 4096,
  parameter int MARGIN     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic             response,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
`ifdef ROPUF_MARGIN_EN
  ,output logic            unstable
`endif
);

  localparam int TMR_MAX = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] TMR_ZERO    = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
  localparam logic [TMR_W-1:0] WINDOW_LOAD = TMR_W'(WINDOW_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = (SETTLE_CYC > 0) ? TMR_W'(SETTLE_CYC - 1) : {TMR_W{1'b0}};
  localparam bit               SKIP_SETTLE = (SETTLE_CYC == 0);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    CMP    = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [TMR_W-1:0] timer;
  logic [1:0]       sync_a;
  logic [1:0]       sync_b;
  logic             prev_a;
  logic             prev_b;
  logic             edge_a;
  logic             edge_b;
  logic             accept;
  logic             ro_en_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  // Saturating increment: a counter at full scale stays there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic hit);
    if (hit && (cnt != CNT_MAX)) begin
      sat_inc = cnt + CNT_ONE;
    end else begin
      sat_inc = cnt;
    end
  endfunction

`ifdef ROPUF_MARGIN_EN
  localparam logic [CNT_W:0] MARGIN_V = (CNT_W+1)'(MARGIN);

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    if (a > b) begin
      abs_diff = a - b;
    end else begin
      abs_diff = b - a;
    end
  endfunction
`endif

  assign edge_a = sync_a[1] & ~prev_a;
  assign edge_b = sync_b[1] & ~prev_b;
  // A start arriving while done is still high is dropped; the next IDLE cycle accepts again.
  assign accept = (state == IDLE) & start & ~done;

  // Two-flop synchronizers plus previous-value flops for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 2'b00;
      sync_b <= 2'b00;
      prev_a <= 1'b0;
      prev_b <= 1'b0;
    end else begin
      sync_a <= {sync_a[0], ro_a};
      sync_b <= {sync_b[0], ro_b};
      prev_a <= sync_a[1];
      prev_b <= sync_b[1];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = SKIP_SETTLE ? COUNT : SETTLE;
        end else begin
          next_state = IDLE;
        end
      end
      SETTLE: begin
        if (timer == TMR_ZERO) begin
          next_state = COUNT;
        end else begin
          next_state = SETTLE;
        end
      end
      COUNT: begin
        if (timer == TMR_ZERO) begin
          next_state = CMP;
        end else begin
          next_state = COUNT;
        end
      end
      CMP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    ro_en_nxt = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (next_state)
      IDLE: begin
        ro_en_nxt = 1'b0;
        busy_nxt  = 1'b0;
      end
      SETTLE, COUNT: begin
        ro_en_nxt = 1'b1;
        busy_nxt  = 1'b1;
      end
      CMP: begin
        ro_en_nxt = 1'b0;
        busy_nxt  = 1'b1;
      end
      default: begin
        ro_en_nxt = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
    if (state == CMP) begin
      done_nxt = 1'b1;
    end else begin
      done_nxt = 1'b0;
    end
  end

  // Registered control outputs; ro_en drops asynchronously with rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ro_en <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      ro_en <= ro_en_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Down-counting phase timer; it holds N-1 on entry so a phase lasts exactly N cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= TMR_ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            timer <= SKIP_SETTLE ? WINDOW_LOAD : SETTLE_LOAD;
          end else begin
            timer <= timer;
          end
        end
        SETTLE: begin
          if (timer == TMR_ZERO) begin
            timer <= WINDOW_LOAD;
          end else begin
            timer <= timer - TMR_ONE;
          end
        end
        COUNT: begin
          if (timer != TMR_ZERO) begin
            timer <= timer - TMR_ONE;
          end else begin
            timer <= timer;
          end
        end
        default: timer <= timer;
      endcase
    end
  end

  // Edge counters: cleared on accepted start, advanced only during the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_a <= {CNT_W{1'b0}};
      count_b <= {CNT_W{1'b0}};
    end else if (accept) begin
      count_a <= {CNT_W{1'b0}};
      count_b <= {CNT_W{1'b0}};
    end else if (state == COUNT) begin
      count_a <= sat_inc(count_a, edge_a);
      count_b <= sat_inc(count_b, edge_b);
    end else begin
      count_a <= count_a;
      count_b <= count_b;
    end
  end

  // Result register, written once per measurement in CMP; a tie reads as 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      response <= 1'b0;
    end else if (state == CMP) begin
      response <= (count_a > count_b);
    end else begin
      response <= response;
    end
  end

`ifdef ROPUF_MARGIN_EN
  // Margin flag, captured alongside response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unstable <= 1'b0;
    end else if (state == CMP) begin
      unstable <= ({1'b0, abs_diff(count_a, count_b)} < MARGIN_V);
    end else begin
      unstable <= unstable;
    end
  end
`endif

endmodule

// File: tb/tb_ro_puf_reader.sv
`timescale 1ns/1ps
// Bench for ro_puf_reader: free-running oscillators with timestamped rising edges; expected
// counts are the number of oscillator rises inside the sampled window, saturated per counter width.
module tb_ro_puf_reader;

  localparam int S   = 64;
  localparam int W   = 4096;
  localparam int LAT = S + W + 1;
  localparam int SAT_W = 4;
  localparam longint SAT_MAX = 15;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic ro_a;
  logic ro_b_osc;
  logic same_ro;
  logic ro_b;

  logic        ro_en, busy, done, response;
  logic [15:0] count_a, count_b;
  logic        s_ro_en, s_busy, s_done, s_response;
  logic [SAT_W-1:0] s_count_a, s_count_b;
`ifdef ROPUF_MARGIN_EN
  logic        unstable, s_unstable;
`endif

  int ha = 200;
  int hb = 250;
  longint rises_a[$];
  longint rises_b[$];
  int n_cmp = 0;
  int n_err = 0;

  assign ro_b = same_ro ? ro_a : ro_b_osc;

  ro_puf_reader #(.CNT_W(16), .SETTLE_CYC(S), .WINDOW_CYC(W), .MARGIN(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en(ro_en), .busy(busy), .done(done), .response(response),
    .count_a(count_a), .count_b(count_b)
`ifdef ROPUF_MARGIN_EN
    ,.unstable(unstable)
`endif
  );

  ro_puf_reader #(.CNT_W(SAT_W), .SETTLE_CYC(S), .WINDOW_CYC(W), .MARGIN(4)) u_sat (
    .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en(s_ro_en), .busy(s_busy), .done(s_done), .response(s_response),
    .count_a(s_count_a), .count_b(s_count_b)
`ifdef ROPUF_MARGIN_EN
    ,.unstable(s_unstable)
`endif
  );

  always #5 clk = ~clk;

  // Even half-periods starting at t=2 keep every oscillator edge off the clock edges.
  initial begin
    ro_a = 1'b0;
    #2;
    forever begin
      #(ha) ro_a = ~ro_a;
    end
  end

  initial begin
    ro_b_osc = 1'b0;
    #2;
    forever begin
      #(hb) ro_b_osc = ~ro_b_osc;
    end
  end

  always @(posedge ro_a) rises_a.push_back($time);
  always @(posedge ro_b) rises_b.push_back($time);

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint rises_in(input longint q[$], input longint lo, input longint hi);
    longint c = 0;
    foreach (q[i]) if (q[i] > lo && q[i] <= hi) c++;
    return c;
  endfunction

  function automatic longint sat(input longint v);
    return (v > SAT_MAX) ? SAT_MAX : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One measurement; pulse_at raises start for the edge after that many cycles past acceptance.
  task automatic measure(input int new_ha, input int new_hb, input bit same, input int pulse_at);
    int n, lat, dones;
    longint t_acc, lo, hi, ea, eb, sa, sb;
    ha = new_ha;
    hb = new_hb;
    same_ro = same;
    n = 0;
    while ((busy || done) && n < 20) begin
      tick();
      n++;
    end
    repeat (2) tick();
    rises_a.delete();
    rises_b.delete();
    start = 1'b1;
    @(posedge clk);
    t_acc = $time;
    #1;
    start = 1'b0;
    check_val("busy_on", busy, 1);
    check_val("ro_en_on", ro_en, 1);
    check_val("clear_a", count_a, 0);
    lat = -1;
    dones = 0;
    n = 0;
    while (n < LAT + 3) begin
      start = (n == pulse_at);
      tick();
      n++;
      if (done) begin
        dones++;
        if (lat < 0) lat = n;
      end
      if (n == S + W / 2) check_val("ro_en_mid", ro_en, 1);
    end
    start = 1'b0;
    lo = t_acc + 10 * S - 20;
    hi = t_acc + 10 * (S + W) - 20;
    ea = rises_in(rises_a, lo, hi);
    eb = rises_in(rises_b, lo, hi);
    sa = sat(ea);
    sb = sat(eb);
    check_val("latency", lat, LAT);
    check_val("done_pulses", dones, 1);
    check_val("busy_after", busy, 0);
    check_val("ro_en_after", ro_en, 0);
    check_val("count_a", count_a, ea);
    check_val("count_b", count_b, eb);
    check_val("response", response, (ea > eb) ? 1 : 0);
    check_val("sat_count_a", s_count_a, sa);
    check_val("sat_count_b", s_count_b, sb);
    check_val("sat_response", s_response, (sa > sb) ? 1 : 0);
`ifdef ROPUF_MARGIN_EN
    check_val("unstable", unstable, (((ea > eb) ? ea - eb : eb - ea) < 4) ? 1 : 0);
`endif
  endtask

  task automatic reset_mid_count();
    int n;
    int dones;
    repeat (2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (n < S + 2000) begin
      tick();
      n++;
    end
    rst = 1'b1;
    #1;
    check_val("rst_ro_en", ro_en, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_count_a", count_a, 0);
    check_val("rst_count_b", count_b, 0);
    dones = 0;
    repeat (4) begin
      tick();
      if (done) dones++;
    end
    rst = 1'b0;
    repeat (4) begin
      tick();
      if (done) dones++;
    end
    check_val("rst_no_done", dones, 0);
    check_val("rst_idle", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    same_ro = 1'b0;
    repeat (3) tick();
    check_val("reset_ro_en", ro_en, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_done", done, 0);
    check_val("reset_response", response, 0);
    check_val("reset_count_a", count_a, 0);
    check_val("reset_count_b", count_b, 0);
`ifdef ROPUF_MARGIN_EN
    check_val("reset_unstable", unstable, 0);
`endif
    rst = 1'b0;
    repeat (2) tick();

    measure(200, 250, 1'b0, -1);
    measure(250, 200, 1'b0, -1);
    measure(248, 248, 1'b1, -1);
    measure(50, 250, 1'b0, -1);
    measure(200, 250, 1'b0, S + 100);
    measure(250, 200, 1'b0, LAT);
    reset_mid_count();
    measure(200, 250, 1'b0, -1);
    for (int r = 0; r < 3; r++) begin
      int a_h, b_h;
      bit sm;
      a_h = 2 * int'($urandom_range(15, 200));
      b_h = 2 * int'($urandom_range(15, 200));
      sm = ($urandom_range(0, 3) == 0);
      measure(a_h, b_h, sm, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
